// File: rtl/frontend_pkg.sv
// Shared front-end types and widths used by fetch, decode, rename and the
// fetch queue. One {pc, instr} pair is the unit that moves between stages.
package frontend_pkg;

  localparam int FETCH_W  = 2;   // lanes per cycle on fetch and decode sides
  localparam int XLEN     = 32;  // PC / instruction width
  localparam int FQ_DEPTH = 8;   // default fetch queue depth

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch queue: decoupling instruction buffer between fetch and decode.
// Absorbs imem latency and decode back-pressure, presents the oldest
// entries in program order and empties in one cycle on a redirect flush.
//
// Handshake: enqueue happens when enq_ready & |enq_valid & ~flush; every
// valid lane is taken, compacted into consecutive slots in lane order.
// enq_ready depends only on registered count (no path from deq_ready).
// Dequeue happens when deq_ready is high: all presented valid lanes retire
// together (no partial acceptance). deq_valid is thermometer-coded with
// lane 0 oldest, and is forced low during a flush.
module fetch_queue
  import frontend_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [FETCH_W-1:0]          enq_valid,
  input  logic [FETCH_W*XLEN-1:0]     enq_pc,
  input  logic [FETCH_W*XLEN-1:0]     enq_instr,
  output logic                        enq_ready,
  output logic [FETCH_W-1:0]          deq_valid,
  output logic [FETCH_W*XLEN-1:0]     deq_pc,
  output logic [FETCH_W*XLEN-1:0]     deq_instr,
  input  logic                        deq_ready,
  output logic [$clog2(DEPTH+1)-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  // Highest occupancy at which a full FETCH_W-wide group still fits.
  localparam logic [CNT_W-1:0] ENQ_LIMIT = CNT_W'(DEPTH - FETCH_W);

  // Number of set lanes in a lane mask.
  function automatic logic [CNT_W-1:0] popcount(input logic [FETCH_W-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int j = 0; j < FETCH_W; j++) begin
      if (v[j]) n = n + CNT_W'(1);
    end
    return n;
  endfunction

  // Slot offset of a lane after compaction: number of valid lanes below it.
  function automatic logic [PTR_W-1:0] lanes_below(input logic [FETCH_W-1:0] v,
                                                   input int              lane);
    logic [PTR_W-1:0] n;
    n = '0;
    for (int j = 0; j < FETCH_W; j++) begin
      if (j < lane && v[j]) n = n + PTR_W'(1);
    end
    return n;
  endfunction

  fetch_entry_t      mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              enq_fire;
  logic              deq_fire;
  logic [CNT_W-1:0]  n_enq;
  logic [CNT_W-1:0]  n_deq;
  logic [PTR_W-1:0]  wr_idx [FETCH_W];

  // Enqueue side: ready from registered count only, compacted write slots.
  always_comb begin
    enq_ready = (count <= ENQ_LIMIT);
    enq_fire  = enq_ready & (|enq_valid) & ~flush;
    n_enq     = enq_fire ? popcount(enq_valid) : '0;
    for (int i = 0; i < FETCH_W; i++) begin
      wr_idx[i] = wr_ptr + lanes_below(enq_valid, i);
    end
  end

  // Dequeue side: head entries presented straight from storage, data gated
  // to zero on invalid lanes so decode never sees stale words.
  always_comb begin
    fetch_entry_t     head;
    logic [PTR_W-1:0] rd_idx;
    deq_pc    = '0;
    deq_instr = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      deq_valid[i] = (count > CNT_W'(i)) & ~flush;
      rd_idx       = rd_ptr + PTR_W'(i);
      head         = mem[rd_idx];
      if (deq_valid[i]) begin
        deq_pc[i*XLEN +: XLEN]    = head.pc;
        deq_instr[i*XLEN +: XLEN] = head.instr;
      end
    end
    deq_fire = deq_ready & (|deq_valid);
    n_deq    = deq_fire ? popcount(deq_valid) : '0;
  end

  // Pointer and occupancy state; flush returns everything to the origin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(n_deq);
      wr_ptr <= wr_ptr + PTR_W'(n_enq);
      count  <= count + n_enq - n_deq;
    end
  end

  // Storage array: written only on an accepted enqueue, never reset.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (enq_valid[i]) begin
          mem[wr_idx[i]] <= '{pc: enq_pc[i*XLEN +: XLEN], instr: enq_instr[i*XLEN +: XLEN]};
        end
      end
    end
  end

  // Occupancy never exceeds the array size.
  a_count_bound: assert property (@(posedge clk) disable iff (!reset)
    count <= CNT_W'(DEPTH));

  // A refused enqueue must not move the write pointer.
  a_no_enq_when_full: assert property (@(posedge clk) disable iff (!reset)
    (!enq_ready && !flush) |=> (wr_ptr == $past(wr_ptr)));

  // Valid lanes are always a contiguous run starting at lane 0.
  a_deq_thermo: assert property (@(posedge clk) disable iff (!reset)
    (deq_valid & FETCH_W'(deq_valid + FETCH_W'(1))) == '0);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a queue-based scoreboard of {pc,instr}.
module tb_fetch_queue;
  import frontend_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH+1);

  // ---------------- clock / reset ----------------
  logic                     clk;
  logic                     reset;
  logic                     flush;
  logic [FETCH_W-1:0]       enq_valid;
  logic [FETCH_W*XLEN-1:0]  enq_pc;
  logic [FETCH_W*XLEN-1:0]  enq_instr;
  logic                     enq_ready;
  logic [FETCH_W-1:0]       deq_valid;
  logic [FETCH_W*XLEN-1:0]  deq_pc;
  logic [FETCH_W*XLEN-1:0]  deq_instr;
  logic                     deq_ready;
  logic [CNT_W-1:0]         count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_pc    (enq_pc),
    .enq_instr (enq_instr),
    .enq_ready (enq_ready),
    .deq_valid (deq_valid),
    .deq_pc    (deq_pc),
    .deq_instr (deq_instr),
    .deq_ready (deq_ready),
    .count     (count)
  );

  // ---------------- scoreboard ----------------
  logic [2*XLEN-1:0] exp_q[$];   // {pc, instr}, oldest at front
  int n_pass;
  int n_total;
  int n_fail;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One cycle: drive inputs, check outputs mid-cycle against the model,
  // then update the model with what this cycle should have done.
  task automatic step(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                      input logic dr, input logic fl, input string tag);
    logic [31:0] i0, i1;
    int          n_vis;
    logic [1:0]  exp_dv;
    logic        exp_er;
    logic [63:0] e;
    i0 = $urandom_range(32'h7fff_ffff, 0);
    i1 = $urandom_range(32'h7fff_ffff, 0);
    enq_valid = v;
    enq_pc    = {p1, p0};
    enq_instr = {i1, i0};
    deq_ready = dr;
    flush     = fl;
    #3;
    n_vis  = fl ? 0 : (exp_q.size() > FETCH_W ? FETCH_W : exp_q.size());
    exp_dv = (n_vis == 2) ? 2'b11 : (n_vis == 1) ? 2'b01 : 2'b00;
    exp_er = (DEPTH - exp_q.size()) >= FETCH_W;
    check({tag, ".count"},     64'(count),     64'(exp_q.size()));
    check({tag, ".deq_valid"}, 64'(deq_valid), 64'(exp_dv));
    check({tag, ".enq_ready"}, 64'(enq_ready), 64'(exp_er));
    for (int l = 0; l < FETCH_W; l++) begin
      if (l < n_vis) begin
        e = exp_q[l];
        check({tag, ".pc"},    64'(deq_pc[l*XLEN +: XLEN]),    64'(e[63:32]));
        check({tag, ".instr"}, 64'(deq_instr[l*XLEN +: XLEN]), 64'(e[31:0]));
      end else begin
        check({tag, ".pc_gated"}, 64'(deq_pc[l*XLEN +: XLEN]), 64'd0);
      end
    end
    if (fl) begin
      exp_q.delete();
    end else begin
      if (dr) repeat (n_vis) void'(exp_q.pop_front());
      if (exp_er) begin
        if (v[0]) exp_q.push_back({p0, i0});
        if (v[1]) exp_q.push_back({p1, i1});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH && exp_q.size() > 0; k++) step(2'b00, 0, 0, 1'b1, 1'b0, "drain");
    check("drain.empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] pc;

  initial begin
    n_pass = 0; n_total = 0; n_fail = 0;
    reset = 1'b0; flush = 1'b0; enq_valid = '0; enq_pc = '0; enq_instr = '0; deq_ready = 1'b0;

    // 1: reset held two cycles, then idle
    repeat (2) @(posedge clk);
    #1;
    check("rst.count",     64'(count),     64'd0);
    check("rst.deq_valid", 64'(deq_valid), 64'd0);
    check("rst.enq_ready", 64'(enq_ready), 64'd1);
    reset = 1'b1;
    repeat (2) step(2'b00, 0, 0, 1'b0, 1'b0, "idle");

    // 2: one pair, visible next cycle in program order
    step(2'b11, 32'h0, 32'h4, 1'b0, 1'b0, "enq2");
    step(2'b00, 0, 0, 1'b0, 1'b0, "see2");
    drain();

    // 3: fill to 8, fifth group dropped, then drain four pairs
    pc = 32'h0;
    for (int k = 0; k < 4; k++) begin
      step(2'b11, pc, pc + 4, 1'b0, 1'b0, "fill");
      pc += 8;
    end
    step(2'b11, 32'h100, 32'h104, 1'b0, 1'b0, "full_drop");
    for (int k = 0; k < 4; k++) step(2'b00, 0, 0, 1'b1, 1'b0, "drain_full");
    step(2'b00, 0, 0, 1'b0, 1'b0, "empty");

    // 4: single upper lane lands in lane 0
    step(2'b10, 32'hdead, 32'h14, 1'b0, 1'b0, "enq10");
    step(2'b00, 0, 0, 1'b0, 1'b0, "see10");
    drain();

    // 5: steady state at 6 with concurrent enq/deq across pointer wrap
    pc = 32'h200;
    for (int k = 0; k < 3; k++) begin
      step(2'b11, pc, pc + 4, 1'b0, 1'b0, "prefill");
      pc += 8;
    end
    for (int k = 0; k < 20; k++) begin
      step(2'b11, pc, pc + 4, 1'b1, 1'b0, "stream");
      pc += 8;
    end
    check("stream.count6", 64'(count), 64'd6);
    drain();

    // 6: flush at count 5 drops enq, then async reset mid-enqueue
    step(2'b11, 32'h300, 32'h304, 1'b0, 1'b0, "pre5");
    step(2'b11, 32'h308, 32'h30c, 1'b0, 1'b0, "pre5");
    step(2'b01, 32'h310, 32'h0,   1'b0, 1'b0, "pre5");
    check("pre5.count", 64'(count), 64'd5);
    step(2'b11, 32'h400, 32'h404, 1'b1, 1'b1, "flush");
    step(2'b00, 0, 0, 1'b0, 1'b0, "post_flush");
    step(2'b11, 32'h500, 32'h504, 1'b0, 1'b0, "pre_rst");
    enq_valid = 2'b11; enq_pc = {32'h50c, 32'h508};
    #2;
    reset = 1'b0;
    #1;
    exp_q.delete();
    check("arst.count",     64'(count),     64'd0);
    check("arst.deq_valid", 64'(deq_valid), 64'd0);
    check("arst.enq_ready", 64'(enq_ready), 64'd1);
    check("arst.deq_pc",    64'(deq_pc[XLEN-1:0]), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(2'b00, 0, 0, 1'b0, 1'b0, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
